// File: rtl/spmv_pkg.sv
// Shared constants and state encoding for the SpMV sequencer and its datapath.
package spmv_pkg;

    // Default widths and latencies. The sequencer and the datapath both use these values.
    localparam int SPMV_ADDR_W   = 11;
    localparam int SPMV_ROW_W    = 9;
    localparam int SPMV_DATA_W   = 24;
    localparam int SPMV_PIPE_LAT = 8;
    localparam int SPMV_TREE_LAT = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_DRAIN = 3'd2,
        ST_FLUSH = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/pulse_delay.sv
// Pipelined single-bit delay line. A pulse entering on one cycle leaves DEPTH cycles later.
// Back-to-back pulses stay back-to-back.
module pulse_delay #(
    parameter int DEPTH = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic pulse_in,
    output logic pulse_out
);

    logic [DEPTH-1:0] sr_q;
    logic [DEPTH-1:0] sr_d;

    generate
        if (DEPTH == 1) begin : g_one
            // A single stage simply registers the input.
            always_comb sr_d = pulse_in;
        end else begin : g_multi
            // Shift the input into stage 0 and move the older pulses one stage along.
            always_comb sr_d = {sr_q[DEPTH-2:0], pulse_in};
        end
    endgenerate

    // Shift register with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) sr_q <= '0;
        else       sr_q <= sr_d;
    end

    assign pulse_out = sr_q[DEPTH-1];

endmodule

// File: rtl/spmv_sequencer.sv
// Top-level SpMV sequencer. It issues the Y SRAM reads, drains the pipeline and writes
// each completed row sum, tagged with its row index, to the result SRAM.
module spmv_sequencer
    import spmv_pkg::*;
#(
    parameter int ADDR_W   = SPMV_ADDR_W,
    parameter int ROW_W    = SPMV_ROW_W,
    parameter int DATA_W   = SPMV_DATA_W,
    parameter int PIPE_LAT = SPMV_PIPE_LAT,
    parameter int TREE_LAT = SPMV_TREE_LAT
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] num_words,
    input  logic              new_row_flag,
    input  logic [DATA_W-1:0] row_sum,
    output logic [ADDR_W-1:0] addressY,
    output logic              y_read_en,
    output logic              result_we,
    output logic [ROW_W-1:0]  result_addr,
    output logic [DATA_W-1:0] result_data,
    output logic              busy,
    output logic              done
);

    localparam int WAIT_MAX = (PIPE_LAT > TREE_LAT) ? PIPE_LAT : TREE_LAT;
    localparam int CNT_W    = $clog2(WAIT_MAX + 1);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] nw_q, nw_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              ren_q, ren_d;
    logic              seen_q, seen_d;
    logic [ROW_W-1:0]  row_cnt_q, row_cnt_d;
    logic              we_q, we_d;
    logic [ROW_W-1:0]  waddr_q, waddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              capture;
    logic              flush_pulse;
    logic              row_in;
    logic              row_tap;

    // The result write register is the last stage of the boundary delay. The line itself
    // is therefore one stage shorter than TREE_LAT, and row_sum is sampled on the edge
    // that raises result_we.
    pulse_delay #(
        .DEPTH(TREE_LAT - 1)
    ) u_row_delay (
        .clock    (clock),
        .reset    (reset),
        .pulse_in (row_in),
        .pulse_out(row_tap)
    );

    // Next-state logic: FSM transitions, address/wait counters, row capture and write-back.
    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        nw_d        = nw_q;
        cnt_d       = cnt_q;
        ren_d       = 1'b0;
        seen_d      = seen_q;
        row_cnt_d   = row_cnt_q;
        we_d        = 1'b0;
        waddr_d     = waddr_q;
        wdata_d     = wdata_q;
        capture     = 1'b0;
        flush_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    nw_d      = num_words;
                    seen_d    = 1'b0;
                    row_cnt_d = '0;
                    cnt_d     = '0;
                    if (num_words != '0) begin
                        state_d = ST_FETCH;
                        addr_d  = '0;
                        ren_d   = 1'b1;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_FETCH: begin
                capture = 1'b1;
                if (addr_q == nw_q - ADDR_W'(1)) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    addr_d = addr_q + ADDR_W'(1);
                    ren_d  = 1'b1;
                end
            end
            ST_DRAIN: begin
                capture = 1'b1;
                if (cnt_q == CNT_W'(PIPE_LAT - 1)) begin
                    state_d = ST_FLUSH;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_FLUSH: begin
                capture = 1'b1;
                // The last row has no trailing flag, so close it here if one was opened.
                flush_pulse = (cnt_q == '0) && seen_q;
                if (cnt_q == CNT_W'(TREE_LAT - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // The first flag of a pass only opens row 0. Every later flag closes a row.
        row_in = (capture && new_row_flag && seen_q) || flush_pulse;
        if (capture && new_row_flag) seen_d = 1'b1;

        if (row_tap) begin
            we_d      = 1'b1;
            waddr_d   = row_cnt_q;
            wdata_d   = row_sum;
            row_cnt_d = row_cnt_q + ROW_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            nw_q      <= '0;
            cnt_q     <= '0;
            ren_q     <= 1'b0;
            seen_q    <= 1'b0;
            row_cnt_q <= '0;
            we_q      <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            nw_q      <= nw_d;
            cnt_q     <= cnt_d;
            ren_q     <= ren_d;
            seen_q    <= seen_d;
            row_cnt_q <= row_cnt_d;
            we_q      <= we_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign addressY    = addr_q;
    assign y_read_en   = ren_q;
    assign result_we   = we_q;
    assign result_addr = waddr_q;
    assign result_data = wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule
